// File: rtl/int_seq_pkg.sv
// Shared types and vector constants for the interrupt sequencer.
// The state encoding is a plain 3-bit enum so checkers can bind to the debug state output.
package int_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PUSH_PCH = 3'd1,
        ST_PUSH_PCL = 3'd2,
        ST_PUSH_P   = 3'd3,
        ST_VEC_LO   = 3'd4,
        ST_VEC_HI   = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        SRC_RST = 2'd0,
        SRC_NMI = 2'd1,
        SRC_IRQ = 2'd2,
        SRC_BRK = 2'd3
    } source_e;

    localparam logic [15:0] VEC_NMI = 16'hFFFA;
    localparam logic [15:0] VEC_RST = 16'hFFFC;
    localparam logic [15:0] VEC_IRQ = 16'hFFFE;

    // BRK shares the IRQ vector; the B flag in the pushed P tells them apart.
    function automatic logic [15:0] vector_base(input source_e src);
        logic [15:0] base;
        case (src)
            SRC_NMI: base = VEC_NMI;
            SRC_RST: base = VEC_RST;
            default: base = VEC_IRQ;
        endcase
        return base;
    endfunction

endpackage

// File: rtl/int_line_sync.sv
// Multi-flop synchronizer for an active-low async request line, with a falling-edge strobe.
// SYNC_STAGES must be at least 2; flops reset to the inactive (high) level.
module int_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic nrst,
    input  logic line_n_i,
    output logic level_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], line_n_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign fall_o  = prev_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/interrupt_sequencer.sv
// Arbitrates RESET/NMI/IRQ/BRK at instruction boundaries and sequences the
// three stack pushes and two vector fetches, driving the PSR control strobes.
module interrupt_sequencer
    import int_seq_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        nmi_n,
    input  logic        irq_n,
    input  logic        psr_i,
    input  logic        instr_boundary,
    input  logic        brk_instr,
    input  logic        mem_ready,
    output logic        force_brk,
    output logic        busy,
    output logic        push_pch,
    output logic        push_pcl,
    output logic        psr_db_en,
    output logic        break_set,
    output logic        sp_dec,
    output logic        set_i,
    output logic [15:0] vector_addr,
    output logic        vec_fetch,
    output logic        seq_done,
    output logic [2:0]  dbg_state
);

    state_e      state_q, state_d;
    source_e     src_q, src_d;
    logic        b_q, b_d;
    logic        nmi_latch_q, nmi_latch_d;
    logic        reset_pending_q, reset_pending_d;
    logic        nmi_fall, irq_level;
    logic        unused_nmi_level, unused_irq_fall;
    logic        irq_req, not_rst, in_push;
    logic [15:0] vec_base;

    int_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_nmi_sync (
        .clk      (clk),
        .nrst     (nrst),
        .line_n_i (nmi_n),
        .level_o  (unused_nmi_level),
        .fall_o   (nmi_fall)
    );

    int_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_irq_sync (
        .clk      (clk),
        .nrst     (nrst),
        .line_n_i (irq_n),
        .level_o  (irq_level),
        .fall_o   (unused_irq_fall)
    );

    // IRQ is level-sensitive and never latched: masking it drops the request.
    assign irq_req   = ~irq_level & ~psr_i;
    assign not_rst   = (src_q != SRC_RST);
    assign in_push   = (state_q == ST_PUSH_PCH) || (state_q == ST_PUSH_PCL) ||
                       (state_q == ST_PUSH_P);
    assign vec_base  = vector_base(src_q);
    assign dbg_state = state_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q         <= ST_IDLE;
            src_q           <= SRC_RST;
            b_q             <= 1'b0;
            nmi_latch_q     <= 1'b0;
            reset_pending_q <= 1'b1;
        end else begin
            state_q         <= state_d;
            src_q           <= src_d;
            b_q             <= b_d;
            nmi_latch_q     <= nmi_latch_d;
            reset_pending_q <= reset_pending_d;
        end
    end

    // A new edge on the same cycle as the clear must not be lost.
    always_comb begin
        nmi_latch_d = nmi_latch_q;
        if (state_q == ST_VEC_HI && mem_ready && src_q == SRC_NMI) begin
            nmi_latch_d = 1'b0;
        end
        if (nmi_fall) begin
            nmi_latch_d = 1'b1;
        end
    end

    assign reset_pending_d = reset_pending_q &
                             ~((state_q == ST_IDLE) && (state_d == ST_PUSH_PCH));

    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        b_d         = b_q;
        force_brk   = 1'b0;
        busy        = 1'b0;
        push_pch    = 1'b0;
        push_pcl    = 1'b0;
        psr_db_en   = 1'b0;
        break_set   = 1'b0;
        sp_dec      = 1'b0;
        set_i       = 1'b0;
        vector_addr = 16'h0000;
        vec_fetch   = 1'b0;
        seq_done    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (reset_pending_q) begin
                    state_d = ST_PUSH_PCH;
                    src_d   = SRC_RST;
                    b_d     = 1'b0;
                end else if (instr_boundary && (nmi_latch_q || irq_req)) begin
                    state_d   = ST_PUSH_PCH;
                    src_d     = nmi_latch_q ? SRC_NMI : SRC_IRQ;
                    b_d       = 1'b0;
                    force_brk = 1'b1;
                end else if (brk_instr) begin
                    state_d = ST_PUSH_PCH;
                    src_d   = SRC_BRK;
                    b_d     = 1'b1;
                end
            end
            // Reset runs the pushes as dummies: SP still walks down, nothing is written.
            ST_PUSH_PCH: begin
                busy     = 1'b1;
                sp_dec   = 1'b1;
                push_pch = not_rst;
                if (mem_ready) state_d = ST_PUSH_PCL;
            end
            ST_PUSH_PCL: begin
                busy     = 1'b1;
                sp_dec   = 1'b1;
                push_pcl = not_rst;
                if (mem_ready) state_d = ST_PUSH_P;
            end
            ST_PUSH_P: begin
                busy      = 1'b1;
                sp_dec    = 1'b1;
                psr_db_en = not_rst;
                break_set = b_q;
                if (mem_ready) state_d = ST_VEC_LO;
            end
            ST_VEC_LO: begin
                busy        = 1'b1;
                vec_fetch   = 1'b1;
                set_i       = 1'b1;
                vector_addr = vec_base;
                if (mem_ready) state_d = ST_VEC_HI;
            end
            ST_VEC_HI: begin
                busy        = 1'b1;
                vec_fetch   = 1'b1;
                vector_addr = vec_base + 16'd1;
                if (mem_ready) begin
                    seq_done = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A late NMI redirects an IRQ/BRK sequence while the pushes are still
        // running; B keeps its captured value so a hijacked BRK stays visible.
        if (in_push && nmi_latch_q && (src_q == SRC_IRQ || src_q == SRC_BRK)) begin
            src_d = SRC_NMI;
        end
    end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Scoreboard bench for interrupt_sequencer: drivers push one expected record per
// sequence; a negedge monitor accumulates what the DUT did and checks at seq_done.
module tb_interrupt_sequencer;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        nmi_n = 1'b1;
    logic        irq_n = 1'b1;
    logic        psr_i = 1'b0;
    logic        instr_boundary = 1'b0;
    logic        brk_instr = 1'b0;
    logic        mem_ready = 1'b1;
    logic        force_brk, busy, push_pch, push_pcl, psr_db_en, break_set;
    logic        sp_dec, set_i, vec_fetch, seq_done;
    logic [15:0] vector_addr;
    logic [2:0]  dbg_state;

    int compared = 0;
    int mismatched = 0;
    // record: {force_brk, is_reset, b_flag, vector_base}
    logic [18:0] exp_q[$];
    int stall_mode = 0;
    bit nmi_pending = 1'b0;

    always #5 clk = ~clk;

    interrupt_sequencer #(.SYNC_STAGES(2)) dut (
        .clk            (clk),
        .nrst           (nrst),
        .nmi_n          (nmi_n),
        .irq_n          (irq_n),
        .psr_i          (psr_i),
        .instr_boundary (instr_boundary),
        .brk_instr      (brk_instr),
        .mem_ready      (mem_ready),
        .force_brk      (force_brk),
        .busy           (busy),
        .push_pch       (push_pch),
        .push_pcl       (push_pcl),
        .psr_db_en      (psr_db_en),
        .break_set      (break_set),
        .sp_dec         (sp_dec),
        .set_i          (set_i),
        .vector_addr    (vector_addr),
        .vec_fetch      (vec_fetch),
        .seq_done       (seq_done),
        .dbg_state      (dbg_state)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // mem_ready: 0 = always ready, 1 = random stalls, 2 = held off
    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (stall_mode)
                0:       mem_ready = 1'b1;
                1:       mem_ready = ($urandom_range(0, 3) != 0);
                default: mem_ready = 1'b0;
            endcase
        end
    end

    // Monitor
    int          n_sp, n_pch, n_pcl, n_db, n_seti, n_vec;
    logic        bs_seen, last_fb;
    logic [15:0] v0, v1;

    task automatic clear_acc();
        n_sp = 0; n_pch = 0; n_pcl = 0; n_db = 0; n_seti = 0; n_vec = 0;
        bs_seen = 1'b0; v0 = 16'h0; v1 = 16'h0;
    endtask

    initial begin
        logic [18:0] e;
        logic [15:0] hi;
        clear_acc();
        last_fb = 1'b0;
        forever begin
            @(negedge clk);
            if (!nrst) begin
                clear_acc();
                last_fb = 1'b0;
            end else if (!busy) begin
                if (seq_done) chk("seq_done_while_idle", 32'(seq_done), 0);
                last_fb = force_brk;
                clear_acc();
            end else begin
                if (force_brk) chk("force_brk_while_busy", 32'(force_brk), 0);
                if (break_set) bs_seen = 1'b1;
                if (mem_ready) begin
                    n_sp   += 32'(sp_dec);
                    n_pch  += 32'(push_pch);
                    n_pcl  += 32'(push_pcl);
                    n_db   += 32'(psr_db_en);
                    n_seti += 32'(set_i);
                    if (vec_fetch) begin
                        if (n_vec == 0) v0 = vector_addr;
                        else            v1 = vector_addr;
                        n_vec++;
                    end
                end
                if (seq_done) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_sequence", 32'(exp_q.size()), 1);
                    end else begin
                        e  = exp_q.pop_front();
                        hi = e[15:0] + 16'd1;
                        chk("force_brk",  32'(last_fb), 32'(e[18]));
                        chk("vec_lo",     32'(v0), 32'(e[15:0]));
                        chk("vec_hi",     32'(v1), 32'(hi));
                        chk("vec_count",  n_vec, 2);
                        chk("set_i_cnt",  n_seti, 1);
                        chk("sp_dec_cnt", n_sp, 3);
                        chk("pch_cnt",    n_pch, e[17] ? 0 : 1);
                        chk("pcl_cnt",    n_pcl, e[17] ? 0 : 1);
                        chk("db_cnt",     n_db, e[17] ? 0 : 1);
                        chk("break_set",  32'(bs_seen), 32'(e[16]));
                    end
                end
            end
        end
    end

    // Drivers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        repeat (5) tick();
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 300) begin
            tick();
            k++;
        end
        if (busy) chk("idle_timeout", 32'(busy), 0);
    endtask

    // Expected outcome from the arbitration rules: a taken hardware request
    // needs a boundary; NMI beats IRQ and BRK; a latched NMI redirects a BRK.
    task automatic issue(input bit bnd, input bit brk, input bit hijack);
        bit          irq_act, go, fb, b;
        logic [15:0] base;
        int          seen;
        irq_act = (irq_n == 1'b0) && (psr_i == 1'b0);
        go = 1'b0; fb = 1'b0; b = 1'b0; base = 16'hFFFE;
        if (bnd && (nmi_pending || irq_act)) begin
            go = 1'b1; fb = 1'b1;
            base = nmi_pending ? 16'hFFFA : 16'hFFFE;
        end else if (brk) begin
            go = 1'b1; b = 1'b1;
            base = nmi_pending ? 16'hFFFA : 16'hFFFE;
        end
        if (hijack) base = 16'hFFFA;
        if (go) begin
            exp_q.push_back({fb, 1'b0, b, base});
            if (base == 16'hFFFA) nmi_pending = 1'b0;
        end
        instr_boundary = bnd;
        brk_instr      = brk;
        tick();
        instr_boundary = 1'b0;
        brk_instr      = 1'b0;
        if (go) begin
            chk("entry_busy", 32'(busy), 1);
        end else begin
            seen = 0;
            repeat (6) begin
                seen += 32'(busy);
                tick();
            end
            chk("no_entry", seen, 0);
        end
    endtask

    task automatic run_tx(input bit irq_low, input bit mask, input bit bnd, input bit brk,
                          input bit drop_irq);
        irq_n = ~irq_low;
        psr_i = mask;
        settle();
        issue(bnd, brk, 1'b0);
        if (drop_irq) irq_n = 1'b1;
        wait_idle();
        irq_n = 1'b1;
        settle();
    endtask

    task automatic nmi_edge();
        nmi_n = 1'b0;
        repeat (4) tick();
        nmi_n = 1'b1;
        repeat (2) tick();
        nmi_pending = 1'b1;
    endtask

    // NMI edge while a BRK/IRQ sequence is held in PUSH_PCL.
    task automatic hijack_tx(input bit use_irq);
        stall_mode = 0;
        irq_n = ~use_irq;
        psr_i = 1'b0;
        settle();
        issue(use_irq, ~use_irq, 1'b1);
        tick();
        stall_mode = 2;
        nmi_n = 1'b0;
        repeat (6) tick();
        stall_mode = 0;
        nmi_n = 1'b1;
        wait_idle();
        irq_n = 1'b1;
        settle();
    endtask

    task automatic wait_vec_lo();
        int k;
        k = 0;
        while (!set_i && k < 40) begin
            tick();
            k++;
        end
        chk("reach_vec_lo", 32'(set_i), 1);
    endtask

    // NMI edge during VEC_LO: current vector is frozen, NMI stays pending.
    task automatic late_nmi_tx();
        stall_mode = 0;
        irq_n = 1'b0;
        psr_i = 1'b0;
        settle();
        issue(1'b1, 1'b0, 1'b0);
        irq_n = 1'b1;
        wait_vec_lo();
        stall_mode = 2;
        nmi_n = 1'b0;
        repeat (6) tick();
        stall_mode = 0;
        nmi_n = 1'b1;
        wait_idle();
        nmi_pending = 1'b1;
        settle();
    endtask

    task automatic stall_p_tx();
        int k, cnt;
        stall_mode = 0;
        irq_n = 1'b0;
        psr_i = 1'b0;
        settle();
        issue(1'b1, 1'b0, 1'b0);
        irq_n = 1'b1;
        k = 0;
        while (!psr_db_en && k < 40) begin
            tick();
            k++;
        end
        cnt = 32'(psr_db_en);
        stall_mode = 2;
        repeat (3) begin
            tick();
            cnt += 32'(psr_db_en);
        end
        stall_mode = 0;
        tick();
        cnt += 32'(psr_db_en);
        chk("db_hold_cycles", cnt, 4);
        wait_idle();
        settle();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_force_brk"}, 32'(force_brk), 0);
        chk({tag, "_busy"},      32'(busy), 0);
        chk({tag, "_push_pch"},  32'(push_pch), 0);
        chk({tag, "_push_pcl"},  32'(push_pcl), 0);
        chk({tag, "_psr_db_en"}, 32'(psr_db_en), 0);
        chk({tag, "_break_set"}, 32'(break_set), 0);
        chk({tag, "_sp_dec"},    32'(sp_dec), 0);
        chk({tag, "_set_i"},     32'(set_i), 0);
        chk({tag, "_vec_addr"},  32'(vector_addr), 0);
        chk({tag, "_vec_fetch"}, 32'(vec_fetch), 0);
        chk({tag, "_seq_done"},  32'(seq_done), 0);
    endtask

    task automatic release_reset();
        exp_q.push_back({1'b0, 1'b1, 1'b0, 16'hFFFC});
        nrst = 1'b1;
        tick();
        wait_idle();
        settle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        mismatched++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        int kind;
        repeat (3) tick();
        check_all_zero("reset");
        release_reset();

        run_tx(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);   // IRQ taken
        run_tx(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);   // IRQ masked
        run_tx(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);   // BRK
        nmi_edge();
        run_tx(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);   // NMI beats BRK
        hijack_tx(1'b0);
        run_tx(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);   // latch was cleared
        stall_p_tx();
        late_nmi_tx();
        run_tx(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);   // pending NMI served

        repeat (30) begin
            kind = $urandom_range(0, 6);
            stall_mode = $urandom_range(0, 1);
            case (kind)
                0: run_tx(1'b1, 1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                1: run_tx(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
                2: run_tx(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'b1, 1'b0);
                3: begin
                    nmi_edge();
                    run_tx(1'b0, 1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
                end
                4: run_tx(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
                5: hijack_tx(1'($urandom_range(0, 1)));
                default: late_nmi_tx();
            endcase
        end

        // Asynchronous reset in VEC_LO, then a fresh reset sequence.
        stall_mode = 0;
        wait_idle();
        irq_n = 1'b0;
        psr_i = 1'b0;
        settle();
        issue(1'b1, 1'b0, 1'b0);
        irq_n = 1'b1;
        wait_vec_lo();
        #2;
        nrst = 1'b0;
        #1;
        check_all_zero("abort");
        if (exp_q.size() != 0) void'(exp_q.pop_back());
        nmi_pending = 1'b0;
        repeat (3) tick();
        release_reset();

        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/interrupt_sequencer.md
Name: interrupt_sequencer

Overview:
- Responder side of the process status register control interface: consumes the PSR I flag and drives the PSR control strobes (manual_set/manual_I, break_set, DB write enable).
- Arbitrates RESET, NMI, IRQ and BRK at instruction boundaries.
- Sequences the three stack pushes (PCH, PCL, P) and the two vector fetches.
- Sits beside the instruction decoder and RCL in the dataflow.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the nmi_n/irq_n synchronizers (minimum 2).

Ports:
- clk  in  1  system clock
- nrst  in  1  reset, asynchronous, active-low
- nmi_n  in  1  external NMI, async, active-low, edge-sensitive
- irq_n  in  1  external IRQ, async, active-low, level-sensitive
- psr_i  in  1  PSR I flag (PSR_RCL[2])
- instr_boundary  in  1  decoder strobe: next cycle is an opcode fetch
- brk_instr  in  1  decoder: opcode 0x00 fetched this cycle
- mem_ready  in  1  bus handshake; 0 stalls the current sequence state
- force_brk  out  1  decoder substitutes opcode 0x00 (hardware interrupt taken)
- busy  out  1  sequence in progress
- push_pch, push_pcl  out  1  drive PC byte onto DB for a stack write
- psr_db_en  out  1  to PSR enableDBWrite
- break_set  out  1  to PSR break_set; B value for pushed P
- sp_dec  out  1  decrement stack pointer
- set_i  out  1  to PSR manual_set and manual_I (sets I)
- vector_addr  out  16  vector fetch address
- vec_fetch  out  1  vector_addr valid
- seq_done  out  1  one-cycle pulse at sequence end

Behaviour:
- Reset values: all outputs 0, vector_addr 16'h0000, state IDLE, nmi_latch 0, reset_pending 1.
- Sync: nmi_n and irq_n each pass through SYNC_STAGES flops.
  - nmi_latch sets on a synced 1->0 transition.
  - nmi_latch clears on the cycle an NMI-sourced sequence leaves VEC_HI.
  - If set and clear coincide, set wins.
- IRQ request: irq_req = ~irq_sync & ~psr_i, evaluated continuously, never latched.
- States: IDLE, PUSH_PCH, PUSH_PCL, PUSH_P, VEC_LO, VEC_HI.
  - Each non-IDLE state lasts one cycle with mem_ready=1.
  - Each state holds, outputs held, while mem_ready=0.
  - With no stalls a sequence is 5 cycles IDLE->IDLE exclusive.
- Entry from IDLE:
  - reset_pending: entered on the first clock after nrst rises, independent of instr_boundary. source = RST.
  - Otherwise, on instr_boundary the priority is nmi_latch > irq_req: source = NMI or IRQ, force_brk=1 that cycle, B=0.
  - Otherwise brk_instr=1 enters with source = BRK, B=1.
  - A hardware request wins over a simultaneous brk_instr.
- In-state outputs:
  - PUSH_PCH: push_pch=1, sp_dec=1.
  - PUSH_PCL: push_pcl=1, sp_dec=1.
  - PUSH_P: psr_db_en=1, break_set=B, sp_dec=1.
  - source RST: push_pch, push_pcl and psr_db_en forced 0; sp_dec remains 1 (dummy pushes).
  - VEC_LO: vec_fetch=1, set_i=1, vector_addr = base.
  - VEC_HI: vec_fetch=1, vector_addr = base+1, seq_done=1 on exit.
  - busy=1 in every non-IDLE state.
- Vector base: NMI 16'hFFFA, RST 16'hFFFC, IRQ/BRK 16'hFFFE.
- NMI hijack: if nmi_latch is set while in PUSH_PCH..PUSH_P of an IRQ/BRK sequence, source becomes NMI before VEC_LO. B keeps its captured value.
  - Once in VEC_LO, source is frozen.
  - An NMI edge arriving during VEC_LO/VEC_HI stays latched and is served at the next instr_boundary.
- reset_pending clears on entry to PUSH_PCH.
- An async nrst assertion mid-sequence returns to reset values immediately. reset_pending re-arms.
- IRQ deasserted or psr_i set after entry does not abort the sequence.

Decomposition:
- Package int_seq_pkg:
  - state enum (3-bit).
  - source enum {SRC_RST, SRC_NMI, SRC_IRQ, SRC_BRK}.
  - constants VEC_NMI, VEC_RST, VEC_IRQ.
- Sub-module int_line_sync:
  - SYNC_STAGES-deep synchronizer plus falling-edge detect.
  - Instantiated twice. The IRQ instance uses only the level output.

Test Plan:
- Release nrst, mem_ready=1 -> 5-cycle sequence; sp_dec high 3 cycles; push_* and psr_db_en stay 0; vector_addr FFFC then FFFD; set_i in VEC_LO; seq_done once.
- irq_n=0, psr_i=0, instr_boundary pulse -> force_brk=1; PCH, PCL, P pushed with break_set=0; vectors FFFE/FFFF. Repeat with psr_i=1 -> stays IDLE.
- brk_instr=1 with irq_n=1 -> break_set=1 in PUSH_P; vector FFFE. brk_instr and nmi_latch together -> NMI wins, break_set=0, vector FFFA.
- NMI falling edge during PUSH_PCL of a BRK sequence -> vector_addr FFFA/FFFB, break_set still 1; nmi_latch cleared after VEC_HI.
- mem_ready=0 for 3 cycles in PUSH_P -> psr_db_en held 4 cycles; sp_dec counted once per advance.
- nrst asserted in VEC_LO -> all outputs 0 asynchronously; after release a RST sequence runs.
